// File: rtl/proc_run_ctrl_if.sv
// Core / register-file side of the run controller: PC and decode inputs in, clock enable and RF port-1 control out.
// Latency: wiring only. Flow control: none, every signal is valid every cycle.
// Backpressure: none.
interface proc_run_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [PC_W-1:0]   core_pc;
  logic [REG_AW-1:0] core_rs_addr;
  logic              core_reg_write;
  logic [DATA_W-1:0] rf_rd_data;
  logic              cpu_en;
  logic [REG_AW-1:0] rf_rd_addr;
  logic              rf_we;

  modport master (
    input  core_pc, core_rs_addr, core_reg_write, rf_rd_data,
    output cpu_en, rf_rd_addr, rf_we
  );

  modport slave (
    output core_pc, core_rs_addr, core_reg_write, rf_rd_data,
    input  cpu_en, rf_rd_addr, rf_we
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run/halt/step/inspect controller issuing a per-instruction clock enable; PC breakpoint under PROC_RUN_CTRL_BREAKPOINT_EN.
// Latency: step edge -> cpu_en next cycle; RUN issues one 1-cycle cpu_en every TICK_DIV cycles; disp_value lags 1 cycle.
// Backpressure: none; the core always accepts cpu_en, and step edges in RUN/STEP are dropped.
module proc_run_ctrl #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DISP_W   = 16,
  parameter int TICK_DIV = 5000000,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              switch_run,
  input  logic              step_btn,
  input  logic [REG_AW-1:0] switch_select,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_valid,
  proc_run_ctrl_if.master   bus,
  output logic [DISP_W-1:0] disp_value,
  output logic [CNT_W-1:0]  instr_count,
  output logic [1:0]        state,
  output logic              led_indicator
);

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2);

  state_t            state_q, state_d;
  logic              cpu_en_q, cpu_en_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              step_q;
  logic              step_rise;
  logic              tick_wrap;
  logic              bp_hit;
  logic              core_view;
  logic [DISP_W-1:0] disp_d;
  logic              unused_rd;

  assign step_rise = step_btn & ~step_q;
  assign tick_wrap = (tick_q == TICK_LAST);
  assign core_view = (state_q == RUN) || (state_q == STEP);
  assign unused_rd = ^bus.rf_rd_data;

`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
  // skip_bp lets a resume from the breakpoint PC issue that instruction once
  logic skip_bp_q, skip_bp_d;
  assign bp_hit = bp_valid && (bus.core_pc == bp_addr) && !skip_bp_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    tick_d   = tick_q;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
    skip_bp_d = skip_bp_q;
`endif
    case (state_q)
      HALT: begin
        if (switch_run) begin
          state_d = RUN;
          tick_d  = '0;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
          skip_bp_d = 1'b1;
`endif
        end else if (step_rise) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
      RUN: begin
        if (!switch_run) begin
          state_d = HALT;
        end else if (tick_wrap) begin
          tick_d = '0;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
          skip_bp_d = 1'b0;
`endif
          if (bp_hit) state_d  = BREAK;
          else        cpu_en_d = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STEP: state_d = HALT;
      BREAK: begin
        if (!switch_run) begin
          state_d = HALT;
        end else if (step_rise) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    disp_d = bus.rf_rd_data[DISP_W-1:0];
    if (core_view) disp_d = DISP_W'(bus.core_pc);
  end

  always_comb begin
    led_indicator = 1'b1;
    case (state_q)
      HALT:    led_indicator = 1'b0;
      RUN:     led_indicator = (tick_q < TICK_HALF);
      default: led_indicator = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HALT;
      cpu_en_q    <= 1'b0;
      tick_q      <= '0;
      step_q      <= 1'b0;
      disp_value  <= '0;
      instr_count <= '0;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
      skip_bp_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      tick_q     <= tick_d;
      step_q     <= step_btn;
      disp_value <= disp_d;
      if (cpu_en_q) instr_count <= instr_count + 1'b1;
`ifdef PROC_RUN_CTRL_BREAKPOINT_EN
      skip_bp_q  <= skip_bp_d;
`endif
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.rf_we      = bus.core_reg_write & cpu_en_q;
  assign bus.rf_rd_addr = core_view ? bus.core_rs_addr : switch_select;
  assign state          = state_q;

endmodule
